quire_acc_writer: RTL and testbench
===================================

# quire_acc_writer

Write side of the carry-save quire used by the matrix-multiplier datapath. Accepts signed, bit-aligned 64-bit product magnitudes and accumulates each one into two adjacent 80-bit lanes (64-bit fraction plus 16-bit signed carry guard). Lanes live in an even bank (blocks 0,2,4,6) and an odd bank (blocks 1,3,5,7). On flush, the block hands the banks to the downstream carry-resolve/normalise reader, serves its read addresses, clears on its finish pulse, and returns to accumulation.

## Interface
- No parameters. Widths are fixed: 8 blocks × 80 bits, 2-bit bank address.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  product present
- in_ready  out  1  product accepted when in_valid & in_ready
- in_mag  in  64  unsigned product magnitude
- in_sign  in  1  1 = subtract the product
- in_off  in  9  bit offset of in_mag[0] in the 512-bit quire; block k = in_off[8:6], shift s = in_off[5:0]
- flush  in  1  single-cycle request to resolve the quire
- csa_enable  out  1  reader hold/init; high = reader idle, low = reader runs
- adr_even  in  2  reader address into even bank
- adr_odd  in  2  reader address into odd bank
- frac_even  out  80  even_bank[adr_even]; combinational read
- frac_odd  out  80  odd_bank[adr_odd]; combinational read
- rd_finish  in  1  reader finish pulse
- busy  out  1  state != ACCUM or a product is still in the pipeline
- ovf  out  1  sticky: nonzero bits were shifted above block 7
- guard_full  out  1  guard counter saturated; see Configuration

## Operation
- Stage 1 registers the accepted product: k, s, sign, W = {64'b0, in_mag} << s (128 bits).
- Stage 2 does read-modify-write in one cycle from a register array:
  - lane[k] += sx80(L)
  - lane[k+1] += sx80(H)
  - L = W[63:0], H = W[127:64], sx80 = zero-extend to 80 bits.
  - If sign = 1, add the two's-complement negation of each 80-bit value instead.
- Blocks k and k+1 always fall in opposite banks, so each bank takes one write per cycle.
- When k = 7: H is dropped; if H != 0, set ovf. ovf is cleared only by CLEAR or reset.
- Lanes wrap modulo 2^80. Carries between blocks are not propagated here; the reader resolves them.
- States:
  - ACCUM: in_ready = 1, unless guard_full.
    - flush seen → FLUSH_WAIT. in_ready drops the cycle after flush.
    - A product accepted in the same cycle as flush is included in the flush.
  - FLUSH_WAIT: in_ready = 0. Stays until stage 1 and stage 2 are empty (1–2 cycles), then → DRAIN.
  - DRAIN: csa_enable = 0. frac_even/frac_odd follow the reader addresses. rd_finish → CLEAR.
  - CLEAR: zero all 8 lanes, ovf and the guard counter; → ACCUM. Lasts 1 cycle.
- flush outside ACCUM is ignored.
- rd_finish outside DRAIN is ignored.

## Timing
- Reset values: state ACCUM, all lanes 0, pipeline empty, in_ready 1, csa_enable 1, busy 0, ovf 0, guard_full 0. frac_* = 0 until written.
- Accept-to-visible latency: a product accepted at edge N is in the lanes after edge N+2.
- Throughput: 1 product/cycle. Back-to-back products to the same or overlapping blocks need no stall, because the read and write happen in the same cycle.
- csa_enable falls on the edge entering DRAIN and rises on the edge leaving CLEAR.
- Reset asserted mid-DRAIN: immediate return to reset values; csa_enable goes high asynchronously.

## Configuration
- ACC_GUARD_CNT_EN defined:
  - A 15-bit counter increments per accepted product.
  - At 32767 it sets guard_full, forces in_ready = 0 and waits for flush.
  - guard_full clears in CLEAR.
- ACC_GUARD_CNT_EN undefined: no counter; guard_full tied 0; overflow guarding is the software's job.

## Test plan
- Reset, then accept mag = 0x1, off = 0, sign = 0 → after 2 cycles lane0 = 0x1, lane1 = 0, busy = 0.
- Product mag = 0xFFFF_FFFF_FFFF_FFFF, off = 68 (k = 1, s = 4) → lane1 = 0x0_FFFF_FFFF_FFFF_FFF0, lane2 = 0xF.
- Same product with sign = 1 → lane1 = 0xFFFF_0000_0000_0000_0010, lane2 = 0xFFFF_FFFF_FFFF_FFFF_FFF1.
- Product off = 448 + 8 with mag = 0xFF00..00 (upper byte set) → ovf = 1; lane7 holds only the low part; ovf stays 1 until CLEAR.
- Flush with in_valid high in the same cycle:
  - That product appears in frac_even/frac_odd during DRAIN.
  - csa_enable is low until rd_finish.
  - One cycle after rd_finish all lanes read 0, in_ready = 1 and csa_enable = 1.
- With ACC_GUARD_CNT_EN: 32767 continuous products → guard_full = 1 and in_ready = 0 on the next cycle; flush and finish clear both.

Source files
------------

// File: rtl/quire_acc_writer_if.sv
// rtl/quire_acc_writer_if.sv - product input handshake for quire_acc_writer
interface quire_acc_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_mag;
    logic        in_sign;
    logic [8:0]  in_off;

    modport master (output in_valid, in_mag, in_sign, in_off, input in_ready);
    modport slave  (input in_valid, in_mag, in_sign, in_off, output in_ready);
endinterface

// File: rtl/quire_acc_writer.sv
// rtl/quire_acc_writer.sv - carry-save quire write side: 2-stage accumulate, flush/drain/clear FSM
// Optional product guard counter enabled by defining ACC_GUARD_CNT_EN.
module quire_acc_writer (
    input  logic                     clk,
    input  logic                     rst_n,
    quire_acc_writer_if.slave        prod,
    input  logic                     flush,
    output logic                     csa_enable,
    input  logic [1:0]               adr_even,
    input  logic [1:0]               adr_odd,
    output logic [79:0]              frac_even,
    output logic [79:0]              frac_odd,
    input  logic                     rd_finish,
    output logic                     busy,
    output logic                     ovf,
    output logic                     guard_full
);
    typedef enum logic [1:0] {ACCUM, FLUSH_WAIT, DRAIN, CLEAR} state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          csa_enable_q, csa_enable_d;
    logic          ovf_q, ovf_d;

    logic          s1_v_q, s1_v_d;
    logic [2:0]    s1_k_q, s1_k_d;
    logic          s1_sign_q, s1_sign_d;
    logic [127:0]  s1_w_q, s1_w_d;

    logic          s2_v_q, s2_v_d;
    logic [2:0]    s2_k_q, s2_k_d;
    logic [79:0]   s2_lo_q, s2_lo_d;
    logic [79:0]   s2_hi_q, s2_hi_d;

    logic [79:0]   even_q [4];
    logic [79:0]   even_d [4];
    logic [79:0]   odd_q  [4];
    logic [79:0]   odd_d  [4];

    logic          accept;
    logic          gfull_d;
    logic [79:0]   lo_raw, hi_raw;
    logic [1:0]    idx, idx_p1;

    assign accept = prod.in_valid & in_ready_q;

`ifdef ACC_GUARD_CNT_EN
    logic [14:0] gcnt_q, gcnt_d;
    logic        gfull_q;

    always_comb begin
        gcnt_d  = gcnt_q;
        gfull_d = gfull_q;
        if (state_q == CLEAR) begin
            gcnt_d  = '0;
            gfull_d = 1'b0;
        end else if (accept && !gfull_q) begin
            gcnt_d = gcnt_q + 15'd1;
            if (gcnt_d == 15'h7FFF) gfull_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q  <= '0;
            gfull_q <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            gfull_q <= gfull_d;
        end
    end

    assign guard_full = gfull_q;
`else
    assign gfull_d    = 1'b0;
    assign guard_full = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:      if (flush)     state_d = FLUSH_WAIT;
            // Stage 2 retires on the same edge that leaves FLUSH_WAIT.
            FLUSH_WAIT: if (!s1_v_q)   state_d = DRAIN;
            DRAIN:      if (rd_finish) state_d = CLEAR;
            CLEAR:                     state_d = ACCUM;
            default:                   state_d = ACCUM;
        endcase

        in_ready_d   = (state_d == ACCUM) && !gfull_d;
        csa_enable_d = (state_d != DRAIN) && (state_d != CLEAR);

        s1_v_d    = accept;
        s1_k_d    = s1_k_q;
        s1_sign_d = s1_sign_q;
        s1_w_d    = s1_w_q;
        if (accept) begin
            s1_k_d    = prod.in_off[8:6];
            s1_sign_d = prod.in_sign;
            s1_w_d    = {64'b0, prod.in_mag} << prod.in_off[5:0];
        end

        lo_raw  = {16'b0, s1_w_q[63:0]};
        hi_raw  = {16'b0, s1_w_q[127:64]};
        s2_v_d  = s1_v_q;
        s2_k_d  = s1_k_q;
        s2_lo_d = s1_sign_q ? (~lo_raw + 80'd1) : lo_raw;
        s2_hi_d = s1_sign_q ? (~hi_raw + 80'd1) : hi_raw;

        idx    = s2_k_q[2:1];
        idx_p1 = idx + 2'd1;
        even_d = even_q;
        odd_d  = odd_q;
        ovf_d  = ovf_q;
        if (state_q == CLEAR) begin
            for (int i = 0; i < 4; i++) begin
                even_d[i] = '0;
                odd_d[i]  = '0;
            end
            ovf_d = 1'b0;
        end else if (s2_v_q) begin
            // Blocks k and k+1 land in opposite banks, so each bank sees one write.
            if (!s2_k_q[0]) begin
                even_d[idx] = even_q[idx] + s2_lo_q;
                odd_d[idx]  = odd_q[idx] + s2_hi_q;
            end else begin
                odd_d[idx] = odd_q[idx] + s2_lo_q;
                if (idx != 2'd3) even_d[idx_p1] = even_q[idx_p1] + s2_hi_q;
                else if (s2_hi_q != '0) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            in_ready_q   <= 1'b1;
            csa_enable_q <= 1'b1;
            ovf_q        <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_k_q       <= '0;
            s1_sign_q    <= 1'b0;
            s1_w_q       <= '0;
            s2_v_q       <= 1'b0;
            s2_k_q       <= '0;
            s2_lo_q      <= '0;
            s2_hi_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                even_q[i] <= '0;
                odd_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            csa_enable_q <= csa_enable_d;
            ovf_q        <= ovf_d;
            s1_v_q       <= s1_v_d;
            s1_k_q       <= s1_k_d;
            s1_sign_q    <= s1_sign_d;
            s1_w_q       <= s1_w_d;
            s2_v_q       <= s2_v_d;
            s2_k_q       <= s2_k_d;
            s2_lo_q      <= s2_lo_d;
            s2_hi_q      <= s2_hi_d;
            for (int i = 0; i < 4; i++) begin
                even_q[i] <= even_d[i];
                odd_q[i]  <= odd_d[i];
            end
        end
    end

    assign prod.in_ready = in_ready_q;
    assign csa_enable    = csa_enable_q;
    assign ovf           = ovf_q;
    assign busy          = (state_q != ACCUM) || s1_v_q || s2_v_q;
    assign frac_even     = even_q[adr_even];
    assign frac_odd      = odd_q[adr_odd];
endmodule

// File: tb/tb_quire_acc_writer.sv
// tb/tb_quire_acc_writer.sv - directed vector bench for quire_acc_writer
module tb_quire_acc_writer;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        csa_enable;
    logic [1:0]  adr_even;
    logic [1:0]  adr_odd;
    logic [79:0] frac_even;
    logic [79:0] frac_odd;
    logic        rd_finish;
    logic        busy;
    logic        ovf;
    logic        guard_full;

    quire_acc_writer_if bus();

    quire_acc_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod       (bus),
        .flush      (flush),
        .csa_enable (csa_enable),
        .adr_even   (adr_even),
        .adr_odd    (adr_odd),
        .frac_even  (frac_even),
        .frac_odd   (frac_odd),
        .rd_finish  (rd_finish),
        .busy       (busy),
        .ovf        (ovf),
        .guard_full (guard_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [63:0] mag;
        logic        sg;
        logic [8:0]  off;
        int          la;
        logic [79:0] ea;
        int          lb;
        logic [79:0] eb;
        logic        eovf;
    } vec_t;

    vec_t tbl [12];
    int   n_vec;
    int   n_fail;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic rd_lane(input int i, output logic [79:0] v);
        if (i % 2 == 0) begin
            adr_even = i[2:1];
            #1;
            v = frac_even;
        end else begin
            adr_odd = i[2:1];
            #1;
            v = frac_odd;
        end
    endtask

    task automatic chk_lane(input string name, input int i, input logic [79:0] exp);
        logic [79:0] v;
        rd_lane(i, v);
        chk(name, v, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (csa_enable !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chkb(name, csa_enable, 1'b0);
    endtask

    task automatic do_clear();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain("clr_drain_reached");
        rd_finish = 1'b1;
        tick();
        rd_finish = 1'b0;
        tick();
    endtask

    task automatic apply(input logic [63:0] mag, input logic sg, input logic [8:0] off);
        bus.in_valid = 1'b1;
        bus.in_mag   = mag;
        bus.in_sign  = sg;
        bus.in_off   = off;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [79:0] v;
        n_vec = 0;
        n_fail = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        rd_finish = 1'b0;
        adr_even = '0;
        adr_odd = '0;
        bus.in_valid = 1'b0;
        bus.in_mag = '0;
        bus.in_sign = 1'b0;
        bus.in_off = '0;

        tbl[0]  = '{1'b0, 64'h1, 1'b0, 9'd0,   0, 80'h1, 1, 80'h0, 1'b0};
        tbl[1]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 9'd68, 1, 80'h0000_FFFF_FFFF_FFFF_FFF0, 2, 80'hF, 1'b0};
        tbl[2]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 9'd68, 1, 80'hFFFF_0000_0000_0000_0010, 2, 80'hFFFF_FFFF_FFFF_FFFF_FFF1, 1'b0};
        tbl[3]  = '{1'b0, 64'h10, 1'b0, 9'd64, 1, 80'hFFFF_0000_0000_0000_0020, 2, 80'hFFFF_FFFF_FFFF_FFFF_FFF1, 1'b0};
        tbl[4]  = '{1'b0, 64'h1, 1'b0, 9'd63,  0, 80'h0000_8000_0000_0000_0000, 1, 80'hFFFF_0000_0000_0000_0020, 1'b0};
        tbl[5]  = '{1'b0, 64'h1, 1'b0, 9'd127, 1, 80'hFFFF_8000_0000_0000_0020, 2, 80'hFFFF_FFFF_FFFF_FFFF_FFF1, 1'b0};
        tbl[6]  = '{1'b1, 64'hFF00_0000_0000_0001, 1'b0, 9'd456, 7, 80'h100, 6, 80'h0, 1'b1};
        tbl[7]  = '{1'b0, 64'h5, 1'b1, 9'd448, 7, 80'hFB, 0, 80'h0, 1'b1};
        tbl[8]  = '{1'b0, 64'h3, 1'b0, 9'd447, 6, 80'h0000_8000_0000_0000_0000, 7, 80'hFC, 1'b1};
        tbl[9]  = '{1'b1, 64'hABCD, 1'b0, 9'd144, 2, 80'hABCD_0000, 3, 80'h0, 1'b0};
        tbl[10] = '{1'b0, 64'h1, 1'b1, 9'd128, 2, 80'hABCC_FFFF, 3, 80'h0, 1'b0};
        tbl[11] = '{1'b0, 64'hABCD_0000, 1'b1, 9'd128, 2, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 3, 80'h0, 1'b0};

        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chkb("rst_in_ready", bus.in_ready, 1'b1);
        chkb("rst_csa_enable", csa_enable, 1'b1);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_ovf", ovf, 1'b0);
        chkb("rst_guard_full", guard_full, 1'b0);
        chk_lane("rst_lane0", 0, 80'h0);
        chk_lane("rst_lane7", 7, 80'h0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].clr) do_clear();
            apply(tbl[i].mag, tbl[i].sg, tbl[i].off);
            chk_lane($sformatf("v%0d_lane%0d", i, tbl[i].la), tbl[i].la, tbl[i].ea);
            chk_lane($sformatf("v%0d_lane%0d", i, tbl[i].lb), tbl[i].lb, tbl[i].eb);
            chkb($sformatf("v%0d_ovf", i), ovf, tbl[i].eovf);
            chkb($sformatf("v%0d_busy", i), busy, 1'b0);
        end

        // Back-to-back products into the same and overlapping blocks.
        do_clear();
        bus.in_valid = 1'b1;
        bus.in_sign = 1'b0;
        bus.in_mag = 64'h5; bus.in_off = 9'd0;
        tick();
        chkb("b2b_busy", busy, 1'b1);
        bus.in_mag = 64'h7; bus.in_off = 9'd0;
        tick();
        bus.in_mag = 64'h1; bus.in_off = 9'd127;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk_lane("b2b_lane0", 0, 80'hC);
        chk_lane("b2b_lane1", 1, 80'h0000_8000_0000_0000_0000);
        chk_lane("b2b_lane2", 2, 80'h0);
        rd_finish = 1'b1;
        tick();
        rd_finish = 1'b0;
        tick();
        chkb("finish_in_accum_csa", csa_enable, 1'b1);
        chk_lane("finish_in_accum_lane0", 0, 80'hC);

        // Flush with a product in the same cycle.
        bus.in_valid = 1'b1;
        bus.in_mag = 64'h7; bus.in_sign = 1'b0; bus.in_off = 9'd192;
        flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        flush = 1'b0;
        chkb("fw_in_ready", bus.in_ready, 1'b0);
        chkb("fw_busy", busy, 1'b1);
        chkb("fw_csa_enable", csa_enable, 1'b1);
        wait_drain("fw_drain_reached");
        chk_lane("drain_lane3", 3, 80'h7);
        chk_lane("drain_lane0", 0, 80'hC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chkb("drain_csa_hold", csa_enable, 1'b0);
        chkb("drain_busy", busy, 1'b1);
        chk_lane("drain_lane3_hold", 3, 80'h7);
        rd_finish = 1'b1;
        tick();
        rd_finish = 1'b0;
        chkb("clear_csa_enable", csa_enable, 1'b0);
        chkb("clear_in_ready", bus.in_ready, 1'b0);
        tick();
        chkb("post_clear_csa", csa_enable, 1'b1);
        chkb("post_clear_in_ready", bus.in_ready, 1'b1);
        chkb("post_clear_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) chk_lane($sformatf("post_clear_lane%0d", i), i, 80'h0);

        // Reset while draining.
        apply(64'h9, 1'b0, 9'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain("rst_drain_reached");
        #2;
        rst_n = 1'b0;
        #1;
        chkb("async_rst_csa", csa_enable, 1'b1);
        chkb("async_rst_in_ready", bus.in_ready, 1'b1);
        chkb("async_rst_busy", busy, 1'b0);
        rd_lane(0, v);
        chk("async_rst_lane0", v, 80'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef ACC_GUARD_CNT_EN
        bus.in_valid = 1'b1;
        bus.in_mag = 64'h0; bus.in_off = 9'd0; bus.in_sign = 1'b0;
        for (int i = 0; i < 32766; i++) @(posedge clk);
        #1;
        chkb("guard_not_yet", guard_full, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chkb("guard_full_set", guard_full, 1'b1);
        chkb("guard_in_ready", bus.in_ready, 1'b0);
        tick();
        do_clear();
        chkb("guard_cleared", guard_full, 1'b0);
        chkb("guard_ready_back", bus.in_ready, 1'b1);
`else
        bus.in_valid = 1'b1;
        bus.in_mag = 64'h0; bus.in_off = 9'd0; bus.in_sign = 1'b0;
        for (int i = 0; i < 40; i++) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chkb("guard_tied_low", guard_full, 1'b0);
        chkb("guard_ready_stays", bus.in_ready, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
